// File: rtl/mul_functional_unit.sv
// Multiplier functional unit: accepts one operand pair and tag from the MUL
// reservation station, multiplies iteratively (one multiplier bit per cycle,
// LSB first), then holds the result on the CDB request lines until granted.
module mul_functional_unit #(
  parameter int unsigned          WIDTH  = 8,
  parameter int unsigned          TAG_W  = 3,
  parameter logic [WIDTH-1:0]     SANITY = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   MUL_Operand3,
  input  logic [WIDTH-1:0]   MUL_Operand4,
  input  logic [TAG_W-1:0]   MUL_Tag_ip,
  output logic               MUL_Status,
  output logic               CDB_Req,
  input  logic               CDB_Grant,
  output logic [TAG_W-1:0]   CDB_Tag,
  output logic [WIDTH-1:0]   CDB_Data,
  output logic               MUL_Ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESULT
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]     step;
  logic [TAG_W-1:0]     held_tag;
  logic                 issue_valid;

  // A station issue is recognised only when neither operand carries the idle marker.
  always_comb begin
    issue_valid = (MUL_Operand3 != SANITY) && (MUL_Operand4 != SANITY);
  end

  // Partial-product add for the multiplier bit currently in the LSB position.
  always_comb begin
    acc_next = acc + (multiplier[0] ? multiplicand : '0);
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      step         <= '0;
      held_tag     <= '0;
      MUL_Status   <= 1'b0;
      CDB_Req      <= 1'b0;
      CDB_Tag      <= '0;
      CDB_Data     <= SANITY;
      MUL_Ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            multiplicand <= {{WIDTH{1'b0}}, MUL_Operand3};
            multiplier   <= MUL_Operand4;
            held_tag     <= MUL_Tag_ip;
            acc          <= '0;
            step         <= '0;
            MUL_Status   <= 1'b1;
            state        <= COMPUTE;
          end
        end

        COMPUTE: begin
          acc          <= acc_next;
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          step         <= step + 1'b1;
          if (step == LAST_STEP) begin
            CDB_Data <= acc_next[WIDTH-1:0];
            MUL_Ovf  <= |acc_next[2*WIDTH-1:WIDTH];
            CDB_Tag  <= held_tag;
            CDB_Req  <= 1'b1;
            state    <= RESULT;
          end
        end

        RESULT: begin
          if (CDB_Grant) begin
            CDB_Req    <= 1'b0;
            CDB_Data   <= SANITY;
            MUL_Ovf    <= 1'b0;
            MUL_Status <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_functional_unit.sv
// Self-checking bench for mul_functional_unit: reset, table-driven products,
// randomized products against an arithmetic reference, and hand-written
// sequences for grant stalls, ignored issues and mid-operation reset.
module tb_mul_functional_unit;

  localparam int WIDTH = 8;
  localparam int TAG_W = 3;
  localparam logic [WIDTH-1:0] SANITY = 8'hFF;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] MUL_Operand3;
  logic [WIDTH-1:0] MUL_Operand4;
  logic [TAG_W-1:0] MUL_Tag_ip;
  logic             MUL_Status;
  logic             CDB_Req;
  logic             CDB_Grant;
  logic [TAG_W-1:0] CDB_Tag;
  logic [WIDTH-1:0] CDB_Data;
  logic             MUL_Ovf;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
    int               hold;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[7];

  mul_functional_unit #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W),
    .SANITY(SANITY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MUL_Operand3(MUL_Operand3),
    .MUL_Operand4(MUL_Operand4),
    .MUL_Tag_ip  (MUL_Tag_ip),
    .MUL_Status  (MUL_Status),
    .CDB_Req     (CDB_Req),
    .CDB_Grant   (CDB_Grant),
    .CDB_Tag     (CDB_Tag),
    .CDB_Data    (CDB_Data),
    .MUL_Ovf     (MUL_Ovf)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [TAG_W-1:0] t);
    @(negedge clk);
    MUL_Operand3 = a;
    MUL_Operand4 = b;
    MUL_Tag_ip   = t;
  endtask

  // Full transaction: issue, measure latency, check result, stall for 'hold' cycles, grant.
  task automatic runOp(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TAG_W-1:0] t, input int hold,
                       input logic [WIDTH-1:0] exp_data, input logic exp_ovf);
    int cycles;
    CDB_Grant = 1'b0;
    applyStimulus(a, b, t);
    @(negedge clk);
    MUL_Operand3 = SANITY;
    MUL_Operand4 = SANITY;
    checkOutput({name, " busy after issue"}, 32'(MUL_Status), 32'd1);
    cycles = 0;
    while (!CDB_Req && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'd8);
    checkOutput({name, " data"}, 32'(CDB_Data), 32'(exp_data));
    checkOutput({name, " ovf"}, 32'(MUL_Ovf), 32'(exp_ovf));
    checkOutput({name, " tag"}, 32'(CDB_Tag), 32'(t));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, " stall req"}, 32'(CDB_Req), 32'd1);
      checkOutput({name, " stall data"}, 32'(CDB_Data), 32'(exp_data));
    end
    CDB_Grant = 1'b1;
    @(negedge clk);
    CDB_Grant = 1'b0;
    checkOutput({name, " req released"}, 32'(CDB_Req), 32'd0);
    checkOutput({name, " not busy"}, 32'(MUL_Status), 32'd0);
    checkOutput({name, " data idle"}, 32'(CDB_Data), 32'(SANITY));
    checkOutput({name, " ovf idle"}, 32'(MUL_Ovf), 32'd0);
    checkOutput({name, " tag kept"}, 32'(CDB_Tag), 32'(t));
  endtask

  initial begin
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;
    logic [TAG_W-1:0]   rt;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{a: 8'd7,   b: 8'd6,   tag: 3'b100, hold: 0, exp_data: 8'd42,  exp_ovf: 1'b0};
    vecs[1] = '{a: 8'h20,  b: 8'h10,  tag: 3'b001, hold: 1, exp_data: 8'h00,  exp_ovf: 1'b1};
    vecs[2] = '{a: 8'hFE,  b: 8'h01,  tag: 3'b010, hold: 0, exp_data: 8'hFE,  exp_ovf: 1'b0};
    vecs[3] = '{a: 8'h00,  b: 8'h55,  tag: 3'b111, hold: 2, exp_data: 8'h00,  exp_ovf: 1'b0};
    vecs[4] = '{a: 8'hFE,  b: 8'hFE,  tag: 3'b011, hold: 0, exp_data: 8'h04,  exp_ovf: 1'b1};
    vecs[5] = '{a: 8'h10,  b: 8'h0F,  tag: 3'b101, hold: 0, exp_data: 8'hF0,  exp_ovf: 1'b0};
    vecs[6] = '{a: 8'h80,  b: 8'h02,  tag: 3'b110, hold: 3, exp_data: 8'h00,  exp_ovf: 1'b1};

    // Reset held for two edges.
    rst_n        = 1'b0;
    MUL_Operand3 = SANITY;
    MUL_Operand4 = SANITY;
    MUL_Tag_ip   = '0;
    CDB_Grant    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset status", 32'(MUL_Status), 32'd0);
    checkOutput("reset req", 32'(CDB_Req), 32'd0);
    checkOutput("reset data", 32'(CDB_Data), 32'hFF);
    checkOutput("reset ovf", 32'(MUL_Ovf), 32'd0);
    checkOutput("reset tag", 32'(CDB_Tag), 32'd0);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].hold,
            vecs[i].exp_data, vecs[i].exp_ovf);
    end

    $display("[TB] randomized vectors");
    for (int i = 0; i < 25; i++) begin
      ra   = WIDTH'($urandom_range(0, 254));
      rb   = WIDTH'($urandom_range(0, 254));
      rt   = TAG_W'($urandom);
      prod = (2*WIDTH)'(ra) * (2*WIDTH)'(rb);
      runOp($sformatf("rnd%0d", i), ra, rb, rt, int'($urandom_range(0, 3)),
            prod[WIDTH-1:0], prod[2*WIDTH-1:WIDTH] != '0);
    end

    // Long stall with new operands presented while busy; grant coincides with valid operands.
    $display("[TB] stall with operands presented while busy");
    applyStimulus(8'd12, 8'd11, 3'b010);
    @(negedge clk);
    MUL_Operand3 = SANITY;
    MUL_Operand4 = SANITY;
    repeat (8) @(negedge clk);
    checkOutput("stall req up", 32'(CDB_Req), 32'd1);
    checkOutput("stall first data", 32'(CDB_Data), 32'd132);
    MUL_Operand3 = 8'd3;
    MUL_Operand4 = 8'd3;
    MUL_Tag_ip   = 3'b101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall busy", 32'(MUL_Status), 32'd1);
      checkOutput("stall data stable", 32'(CDB_Data), 32'd132);
      checkOutput("stall tag stable", 32'(CDB_Tag), 32'b010);
    end
    CDB_Grant = 1'b1;
    @(negedge clk);
    CDB_Grant = 1'b0;
    checkOutput("grant edge no capture status", 32'(MUL_Status), 32'd0);
    checkOutput("grant edge req", 32'(CDB_Req), 32'd0);
    @(negedge clk);
    checkOutput("3x3 accepted next edge", 32'(MUL_Status), 32'd1);
    MUL_Operand3 = SANITY;
    MUL_Operand4 = SANITY;
    repeat (8) @(negedge clk);
    checkOutput("3x3 req", 32'(CDB_Req), 32'd1);
    checkOutput("3x3 data", 32'(CDB_Data), 32'd9);
    checkOutput("3x3 tag", 32'(CDB_Tag), 32'b101);
    CDB_Grant = 1'b1;
    @(negedge clk);
    CDB_Grant = 1'b0;
    checkOutput("3x3 released", 32'(MUL_Status), 32'd0);

    // Idle marker on one operand with a stray grant: nothing is captured.
    $display("[TB] idle marker operand");
    MUL_Operand3 = 8'hFF;
    MUL_Operand4 = 8'd5;
    CDB_Grant    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("sanity no busy", 32'(MUL_Status), 32'd0);
      checkOutput("sanity no req", 32'(CDB_Req), 32'd0);
    end
    CDB_Grant    = 1'b0;
    MUL_Operand3 = SANITY;

    // Reset on the fourth compute edge abandons the operation.
    $display("[TB] reset mid-operation");
    applyStimulus(8'd9, 8'd9, 3'b011);
    @(negedge clk);
    MUL_Operand3 = SANITY;
    MUL_Operand4 = SANITY;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset status", 32'(MUL_Status), 32'd0);
    checkOutput("midreset req", 32'(CDB_Req), 32'd0);
    checkOutput("midreset data", 32'(CDB_Data), 32'hFF);
    checkOutput("midreset tag", 32'(CDB_Tag), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("midreset no broadcast", 32'(CDB_Req), 32'd0);
    end

    // Unit still works after the abandoned operation.
    runOp("post-reset", 8'd15, 8'd17, 3'b110, 1, 8'd255, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
